gdl_input_packer: RTL and testbench

//  Transmit side of the GDL input connectors. Gathers per-subsystem trigger summaries
//  (CDC, ECL, TOP, KLM, KEKB, GDL-internal) and aligns them with per-source programmable

---
 rtl/gdl_input_packer.sv | 143 ++++++++++++++
 tb/tb_gdl_input_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gdl_input_packer.sv
// gdl_input_packer: aligns GDL input summaries through per-source delay lines, stretches KEKB
// flags and packs everything with a frame tag and even parity into the FTD input words.
// Latency 1 tick + per-source dly; no backpressure, one word is emitted every gclk2 tick.
//
// Ports:
//   gclk2, reset                    trigger clock, synchronous active-high reset
//   cdc_in/ecl_in/top_in/klm_in     subsystem summaries (FTD bits 0..45)
//   kekb_in (revo,her,ler), gdl_in  FTD bits 46..51
//   dly_cdc/ecl/top/klm/misc        extra delay per source (misc = kekb + gdl)
//   stretch                         KEKB flag hold = stretch+1 ticks
//   ftdinb/ftdind/ftdinf            packed FTD words (ftdinf reserved, always 0)

// Per-source delay line: the shift register always holds the last DEPTH samples, and dly
// only picks the tap, so a delay change needs no flush of the line.
module gdl_dly_line #(
    parameter int W     = 8,
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     din,
    input  logic [DLY_W-1:0] dly,
    output logic [W-1:0]     dout
);
    localparam int DEPTH = (1 << DLY_W) - 1;

    logic [W-1:0] sr_q [DEPTH];
    logic [W-1:0] taps [DEPTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    // Tap 0 is the live input so dly=0 costs only the output register.
    always_comb begin
        taps[0] = din;
        for (int i = 1; i <= DEPTH; i++) taps[i] = sr_q[i-1];
    end

    assign dout = taps[dly];
endmodule

module gdl_input_packer #(
    parameter int DLY_W = 4,
    parameter int STR_W = 3
) (
    input  logic             gclk2,
    input  logic             reset,
    input  logic [14:0]      cdc_in,
    input  logic [23:0]      ecl_in,
    input  logic [3:0]       top_in,
    input  logic [2:0]       klm_in,
    input  logic [2:0]       kekb_in,
    input  logic [2:0]       gdl_in,
    input  logic [DLY_W-1:0] dly_cdc,
    input  logic [DLY_W-1:0] dly_ecl,
    input  logic [DLY_W-1:0] dly_top,
    input  logic [DLY_W-1:0] dly_klm,
    input  logic [DLY_W-1:0] dly_misc,
    input  logic [STR_W-1:0] stretch,
    output logic [31:0]      ftdinb,
    output logic [31:0]      ftdind,
    output logic [29:0]      ftdinf
);
    logic [14:0]      cdc_d;
    logic [23:0]      ecl_d;
    logic [3:0]       top_d;
    logic [2:0]       klm_d;
    logic [5:0]       misc_d;
    logic [2:0]       kekb_d;
    logic [2:0]       gdl_d;
    logic [2:0]       kekb_s;
    logic [STR_W-1:0] str_cnt_q [3];
    logic             revo_prev_q;
    logic             revo_rise;
    logic [7:0]       tag_q;
    logic [7:0]       tag_d;
    logic [31:0]      ftdinb_q;
    logic [31:0]      ftdind_q;
    logic [31:0]      ftdinb_d;
    logic [31:0]      ftdind_d;

    gdl_dly_line #(.W(15), .DLY_W(DLY_W)) u_dly_cdc (
        .clk(gclk2), .reset(reset), .din(cdc_in), .dly(dly_cdc), .dout(cdc_d));
    gdl_dly_line #(.W(24), .DLY_W(DLY_W)) u_dly_ecl (
        .clk(gclk2), .reset(reset), .din(ecl_in), .dly(dly_ecl), .dout(ecl_d));
    gdl_dly_line #(.W(4), .DLY_W(DLY_W)) u_dly_top (
        .clk(gclk2), .reset(reset), .din(top_in), .dly(dly_top), .dout(top_d));
    gdl_dly_line #(.W(3), .DLY_W(DLY_W)) u_dly_klm (
        .clk(gclk2), .reset(reset), .din(klm_in), .dly(dly_klm), .dout(klm_d));
    gdl_dly_line #(.W(6), .DLY_W(DLY_W)) u_dly_misc (
        .clk(gclk2), .reset(reset), .din({gdl_in, kekb_in}), .dly(dly_misc), .dout(misc_d));

    assign kekb_d = misc_d[2:0];
    assign gdl_d  = misc_d[5:3];

    // Flag is high while the delayed input is high or its hold counter is still running.
    always_comb begin
        kekb_s = '0;
        for (int b = 0; b < 3; b++) kekb_s[b] = kekb_d[b] | (str_cnt_q[b] != '0);
    end

    // Frame alignment keys off the unstretched delayed revo, so stretch never moves tag 0.
    assign revo_rise = kekb_d[0] & ~revo_prev_q;
    assign tag_d     = revo_rise ? 8'd0 : tag_q + 8'd1;

    always_comb begin
        ftdinb_d     = {ecl_d[16:0], cdc_d};
        ftdind_d     = {1'b0, 3'b000, tag_d, gdl_d, kekb_s, klm_d, top_d, ecl_d[23:17]};
        ftdind_d[31] = ^{ftdinb_d, ftdind_d[30:0]};
    end

    always_ff @(posedge gclk2) begin
        if (reset) begin
            ftdinb_q    <= '0;
            ftdind_q    <= '0;
            tag_q       <= '0;
            revo_prev_q <= 1'b0;
            for (int b = 0; b < 3; b++) str_cnt_q[b] <= '0;
        end else begin
            ftdinb_q    <= ftdinb_d;
            ftdind_q    <= ftdind_d;
            tag_q       <= tag_d;
            revo_prev_q <= kekb_d[0];
            for (int b = 0; b < 3; b++) begin
                if (kekb_d[b]) begin
                    str_cnt_q[b] <= stretch;
                end else if (str_cnt_q[b] != '0) begin
                    str_cnt_q[b] <= str_cnt_q[b] - STR_W'(1);
                end
            end
        end
    end

    assign ftdinb = ftdinb_q;
    assign ftdind = ftdind_q;
    assign ftdinf = '0;
endmodule

// File: tb/tb_gdl_input_packer.sv
// Bench for gdl_input_packer: vector table, directed multi-cycle sequences and a random run
// checked against a history-based reference model (input bit b of the 52-bit input vector
// is FTD bit b, so the expected word is the delayed input vector plus tag and parity).
module tb_gdl_input_packer;
    localparam int HMAX = 4096;

    typedef struct {
        logic [14:0] cdc;
        logic [23:0] ecl;
        logic [3:0]  top;
        logic [2:0]  klm;
        logic [2:0]  kekb;
        logic [2:0]  gdl;
        logic [31:0] exp_b;
        logic [19:0] exp_d;
    } vec_t;

    logic        gclk2 = 1'b0;
    logic        reset;
    logic [14:0] cdc_in;
    logic [23:0] ecl_in;
    logic [3:0]  top_in;
    logic [2:0]  klm_in;
    logic [2:0]  kekb_in;
    logic [2:0]  gdl_in;
    logic [3:0]  dly_cdc, dly_ecl, dly_top, dly_klm, dly_misc;
    logic [2:0]  stretch;
    logic [31:0] ftdinb;
    logic [31:0] ftdind;
    logic [29:0] ftdinf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: inputs seen at post-reset edge n are kept in hist[n % HMAX].
    logic [51:0] hist [HMAX];
    int          edge_n     = 0;
    int          last_rise  = 0;
    int          valid_from = 1;
    bit          tag_known  = 1'b1;

    vec_t vecs [6];

    always #5 gclk2 = ~gclk2;

    gdl_input_packer dut (
        .gclk2(gclk2), .reset(reset),
        .cdc_in(cdc_in), .ecl_in(ecl_in), .top_in(top_in), .klm_in(klm_in),
        .kekb_in(kekb_in), .gdl_in(gdl_in),
        .dly_cdc(dly_cdc), .dly_ecl(dly_ecl), .dly_top(dly_top), .dly_klm(dly_klm),
        .dly_misc(dly_misc), .stretch(stretch),
        .ftdinb(ftdinb), .ftdind(ftdind), .ftdinf(ftdinf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [51:0] hist_at(input int n);
        if (n < 1) return '0;
        return hist[n % HMAX];
    endfunction

    function automatic logic drevo(input int n);
        logic [51:0] a;
        a = hist_at(n - int'(dly_misc));
        return a[46];
    endfunction

    // Expected FTD bits 0..51 at edge n: each field is its input from dly edges ago; a KEKB
    // flag is the OR of its delayed input over the last stretch+1 edges.
    function automatic logic [51:0] model_bits(input int n);
        logic [51:0] v;
        logic [51:0] a;
        logic [2:0]  k;
        a = hist_at(n - int'(dly_cdc));  v[14:0]  = a[14:0];
        a = hist_at(n - int'(dly_ecl));  v[38:15] = a[38:15];
        a = hist_at(n - int'(dly_top));  v[42:39] = a[42:39];
        a = hist_at(n - int'(dly_klm));  v[45:43] = a[45:43];
        a = hist_at(n - int'(dly_misc)); v[51:49] = a[51:49];
        k = '0;
        for (int j = 0; j <= int'(stretch); j++) begin
            a = hist_at(n - j - int'(dly_misc));
            k |= a[48:46];
        end
        v[48:46] = k;
        return v;
    endfunction

    task automatic set_in(input logic [14:0] c, input logic [23:0] e, input logic [3:0] t,
                          input logic [2:0] k, input logic [2:0] kb, input logic [2:0] g);
        cdc_in = c; ecl_in = e; top_in = t; klm_in = k; kekb_in = kb; gdl_in = g;
    endtask

    task automatic set_cfg(input logic [3:0] dc, input logic [3:0] de, input logic [3:0] dt,
                           input logic [3:0] dk, input logic [3:0] dm, input logic [2:0] s);
        dly_cdc = dc; dly_ecl = de; dly_top = dt; dly_klm = dk; dly_misc = dm; stretch = s;
    endtask

    task automatic step();
        bit in_reset;
        in_reset = reset;
        if (!in_reset) begin
            edge_n++;
            hist[edge_n % HMAX] = {gdl_in, kekb_in, klm_in, top_in, ecl_in, cdc_in};
        end
        @(posedge gclk2);
        #1;
        if (in_reset) begin
            edge_n = 0; last_rise = 0; valid_from = 1; tag_known = 1'b1;
        end else if (drevo(edge_n) && !drevo(edge_n - 1)) begin
            last_rise = edge_n;
            if (edge_n - 1 >= valid_from) tag_known = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_model();
        logic [51:0] v;
        check("parity", 32'(^{ftdinb, ftdind}), 32'd0);
        check("ftdinf", 32'(ftdinf), 32'd0);
        if (edge_n >= valid_from) begin
            v = model_bits(edge_n);
            check("rnd_ftdinb", ftdinb, v[31:0]);
            check("rnd_ftdind_fields", 32'(ftdind[19:0]), 32'(v[51:32]));
            check("rnd_ftdind_spare", 32'(ftdind[30:28]), 32'd0);
        end
        if (tag_known) check("rnd_tag", 32'(ftdind[27:20]), 32'((edge_n - last_rise) % 256));
    endtask

    initial begin
        vecs[0] = '{cdc: 15'h5A5A, ecl: 24'h0, top: 4'h0, klm: 3'h0, kekb: 3'h0, gdl: 3'h0,
                    exp_b: 32'h00005A5A, exp_d: 20'h00000};
        vecs[1] = '{cdc: 15'h0, ecl: 24'hFFFFFF, top: 4'h0, klm: 3'h0, kekb: 3'h0, gdl: 3'h0,
                    exp_b: 32'hFFFF8000, exp_d: 20'h0007F};
        vecs[2] = '{cdc: 15'h0, ecl: 24'h0, top: 4'hA, klm: 3'h5, kekb: 3'h0, gdl: 3'h0,
                    exp_b: 32'h00000000, exp_d: 20'h02D00};
        vecs[3] = '{cdc: 15'h0, ecl: 24'h0, top: 4'h0, klm: 3'h0, kekb: 3'h6, gdl: 3'h3,
                    exp_b: 32'h00000000, exp_d: 20'h78000};
        vecs[4] = '{cdc: 15'h0001, ecl: 24'h800001, top: 4'h0, klm: 3'h0, kekb: 3'h0, gdl: 3'h0,
                    exp_b: 32'h00008001, exp_d: 20'h00040};
        vecs[5] = '{cdc: 15'h7FFF, ecl: 24'hFFFFFF, top: 4'hF, klm: 3'h7, kekb: 3'h7, gdl: 3'h7,
                    exp_b: 32'hFFFFFFFF, exp_d: 20'hFFFFF};

        // Reset held with every input high: outputs stay 0, then the first sample appears.
        set_cfg(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        set_in('1, '1, '1, '1, '1, '1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_ftdinb", ftdinb, 32'd0);
            check("reset_ftdind", ftdind, 32'd0);
            check("reset_ftdinf", 32'(ftdinf), 32'd0);
        end
        reset = 1'b0;
        step();
        check("first_ftdinb", ftdinb, 32'hFFFFFFFF);
        check("first_ftdind", ftdind, 32'h000FFFFF);

        // Bit-map vectors with zero delay and no stretch.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(vecs[i].cdc, vecs[i].ecl, vecs[i].top, vecs[i].klm, vecs[i].kekb, vecs[i].gdl);
            step();
            check("vec_ftdinb", ftdinb, vecs[i].exp_b);
            check("vec_ftdind", 32'(ftdind[19:0]), 32'(vecs[i].exp_d));
            check("vec_parity", 32'(^{ftdinb, ftdind}), 32'd0);
        end

        // One-tick ecl_in[3] pulse at edge 1 through dly_ecl = 7 and 15.
        for (int pass = 0; pass < 2; pass++) begin
            set_cfg(4'd0, (pass == 0) ? 4'd7 : 4'd15, 4'd0, 4'd0, 4'd0, 3'd0);
            set_in('0, '0, '0, '0, '0, '0);
            do_reset();
            for (int k = 1; k <= 20; k++) begin
                ecl_in = (k == 1) ? 24'h000008 : 24'h0;
                step();
                check((pass == 0) ? "ecl_dly7" : "ecl_dly15", 32'(ftdinb[18]),
                      32'(k == ((pass == 0) ? 8 : 16)));
            end
        end

        // Stretch 3: single revo pulse holds 4 ticks; a retrigger two ticks later extends to 6.
        for (int pass = 0; pass < 2; pass++) begin
            set_cfg(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd3);
            set_in('0, '0, '0, '0, '0, '0);
            do_reset();
            for (int k = 1; k <= 10; k++) begin
                kekb_in = (k == 1 || (pass == 1 && k == 3)) ? 3'b001 : 3'b000;
                step();
                check((pass == 0) ? "stretch_single" : "stretch_retrig", 32'(ftdind[14]),
                      32'(k <= ((pass == 0) ? 4 : 6)));
            end
        end

        // Frame tag free-runs and wraps, then a revo rise forces tag 0 followed by 1.
        set_cfg(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
        set_in('0, '0, '0, '0, '0, '0);
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            step();
            check("tag_count", 32'(ftdind[27:20]), 32'(k % 256));
        end
        kekb_in = 3'b001;
        step();
        check("revo_flag", 32'(ftdind[14]), 32'd1);
        check("tag_at_revo", 32'(ftdind[27:20]), 32'd0);
        kekb_in = 3'b000;
        step();
        check("tag_after_revo", 32'(ftdind[27:20]), 32'd1);

        // Random inputs and configurations, with a reset pulse in the middle of segment 4.
        for (int seg = 0; seg < 8; seg++) begin
            set_cfg(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                    3'($urandom));
            valid_from = edge_n + 25;
            tag_known  = 1'b0;
            for (int c = 0; c < 250; c++) begin
                if (seg == 4 && c == 100) begin
                    set_in(15'($urandom), 24'($urandom), 4'($urandom), 3'($urandom),
                           3'($urandom), 3'($urandom));
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    check("midreset_ftdinb", ftdinb, 32'd0);
                    check("midreset_ftdind", ftdind, 32'd0);
                end
                set_in(15'($urandom), 24'($urandom), 4'($urandom), 3'($urandom),
                       {2'($urandom), 1'($urandom_range(15) == 0)}, 3'($urandom));
                step();
                check_model();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
